// File: rtl/input_pkg.sv
// Shared definitions for the push-button front end.
// Contents:
//   DEBOUNCE_10MS_25MHZ  - default debounce length, in 25 MHz cycles
//   REPEAT_DELAY_200MS   - default gap from the first strobe to the first repeat
//   REPEAT_PERIOD_100MS  - default gap between later repeat strobes
//   strobe_state_e       - 2-bit strobe FSM encoding (IDLE / DELAY / REPEAT)
//   max_int()            - helper used to size the repeat counter
package input_pkg;

  localparam int DEBOUNCE_10MS_25MHZ = 250000;
  localparam int REPEAT_DELAY_200MS  = 5000000;
  localparam int REPEAT_PERIOD_100MS = 2500000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } strobe_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-FF synchroniser, counter debounce, and a
// strobe FSM that issues a single-cycle move strobe on press, with
// optional auto-repeat while the button stays held.
// Ports:
//   i_clk_25MHz - system clock
//   i_reset     - synchronous, active-high reset
//   i_raw       - asynchronous pad input, active-high
//   o_strobe    - single-cycle move strobe, registered
//   o_held      - debounced button level, registered
module button_channel
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_200MS,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS
) (
  input  logic i_clk_25MHz,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_strobe,
  output logic o_held
);

  localparam int  CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int  RCNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam bit  REP_ON = (REPEAT_EN != 0);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

  logic              s1_q, s1_d, s2_q, s2_d;
  logic              stable_q, stable_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  strobe_state_e     state_q, state_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              strobe_q, strobe_d;
  logic              held_q, held_d;
  logic              active;

  // Synchroniser and debounce: stable only follows s2 after
  // DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_comb begin
    s1_d     = i_raw;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // The FSM only counts the button as pressed while the debounced level is
  // high and is not dropping on this very edge, so a release never lets a
  // strobe slip out on the cycle the level falls.
  assign active = stable_q & stable_d;

  // State register (all channel flops).
  always_ff @(posedge i_clk_25MHz) begin
    if (i_reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
      rcnt_q   <= '0;
      strobe_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      strobe_q <= strobe_d;
      held_q   <= held_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!active) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_DELAY;
        ST_DELAY:  if (REP_ON && rcnt_q == DELAY_LAST) state_d = ST_REPEAT;
        ST_REPEAT: state_d = ST_REPEAT;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic: strobe and repeat counter. Without auto-repeat the
  // counter is frozen in DELAY so it can never wrap while held.
  always_comb begin
    strobe_d = 1'b0;
    rcnt_d   = rcnt_q;
    held_d   = stable_q;
    if (!active) begin
      rcnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          strobe_d = 1'b1;
          rcnt_d   = '0;
        end
        ST_DELAY: begin
          if (REP_ON) begin
            if (rcnt_q == DELAY_LAST) begin
              strobe_d = 1'b1;
              rcnt_d   = '0;
            end else begin
              rcnt_d = rcnt_q + RCNT_W'(1);
            end
          end
        end
        ST_REPEAT: begin
          if (rcnt_q == PERIOD_LAST) begin
            strobe_d = 1'b1;
            rcnt_d   = '0;
          end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
          end
        end
        default: rcnt_d = '0;
      endcase
    end
  end

  assign o_strobe = strobe_q;
  assign o_held   = held_q;

endmodule

// File: rtl/button_conditioner.sv
// Front end for the two movement push-buttons. Each button gets its own
// independent channel (synchroniser, debounce, strobe FSM); pressing both
// strobes both outputs and the ship stage resolves that as a hold.
// Ports:
//   i_clk_25MHz       - system clock, 25 MHz
//   i_reset           - synchronous, active-high reset
//   i_left_raw        - asynchronous left pad input, active-high
//   i_right_raw       - asynchronous right pad input, active-high
//   o_left_debounced  - single-cycle left move strobe
//   o_right_debounced - single-cycle right move strobe
//   o_left_held       - debounced left level
//   o_right_held      - debounced right level
module button_conditioner
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_200MS,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS
) (
  input  logic i_clk_25MHz,
  input  logic i_reset,
  input  logic i_left_raw,
  input  logic i_right_raw,
  output logic o_left_debounced,
  output logic o_right_debounced,
  output logic o_left_held,
  output logic o_right_held
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1) begin : g_bad_delay
    $error("button_conditioner: REPEAT_DELAY must be >= 1");
  end
  if (REPEAT_PERIOD < 1) begin : g_bad_period
    $error("button_conditioner: REPEAT_PERIOD must be >= 1");
  end

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_EN      (REPEAT_EN),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_left (
    .i_clk_25MHz(i_clk_25MHz),
    .i_reset    (i_reset),
    .i_raw      (i_left_raw),
    .o_strobe   (o_left_debounced),
    .o_held     (o_left_held)
  );

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_EN      (REPEAT_EN),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_right (
    .i_clk_25MHz(i_clk_25MHz),
    .i_reset    (i_reset),
    .i_raw      (i_right_raw),
    .o_strobe   (o_right_debounced),
    .o_held     (o_right_held)
  );

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with D=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
// Two instances share the inputs: one with auto-repeat, one without.
// Edge numbering: edge_cnt holds the index of the most recent rising edge;
// a strobe produced at edge N is seen by the negedge monitors with edge_cnt==N.
module tb_button_conditioner;

  localparam int D   = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;
  localparam int LAT = D + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic l_raw = 1'b0;
  logic r_raw = 1'b0;
  logic l_stb, r_stb, l_held, r_held;
  logic n_l_stb, n_r_stb, n_l_held, n_r_held;

  always #20 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut (
    .i_clk_25MHz      (clk),
    .i_reset          (rst),
    .i_left_raw       (l_raw),
    .i_right_raw      (r_raw),
    .o_left_debounced (l_stb),
    .o_right_debounced(r_stb),
    .o_left_held      (l_held),
    .o_right_held     (r_held)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_norep (
    .i_clk_25MHz      (clk),
    .i_reset          (rst),
    .i_left_raw       (l_raw),
    .i_right_raw      (r_raw),
    .o_left_debounced (n_l_stb),
    .o_right_debounced(n_r_stb),
    .o_left_held      (n_l_held),
    .o_right_held     (n_r_held)
  );

  typedef struct {
    int   e;
    logic l;
    logic r;
  } exp_t;

  exp_t q_rep[$];
  exp_t q_one[$];
  exp_t xr, xo;
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge clk) begin
    if (edge_cnt > 20000) begin
      $display("FAIL watchdog: edge %0d exceeded budget 20000", edge_cnt);
      $fatal(1, "watchdog expired");
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
  endtask

  task automatic push(input int e, input logic l, input logic r, input bit first);
    q_rep.push_back('{e, l, r});
    if (first) q_one.push_back('{e, l, r});
  endtask

  task automatic wait_edge(input int n);
    while (edge_cnt < n) @(negedge clk);
  endtask

  // Scoreboard monitor, auto-repeat instance.
  always @(negedge clk) begin
    if (q_rep.size() > 0 && q_rep[0].e < edge_cnt) begin
      chk("rep_missed_strobe_edge", -1, q_rep[0].e);
      q_rep.delete(0);
    end
    if (l_stb || r_stb) begin
      if (q_rep.size() == 0) begin
        chk("rep_unexpected_strobe_edge", edge_cnt, -1);
      end else begin
        xr = q_rep.pop_front();
        chk("rep_strobe_edge", edge_cnt, xr.e);
        chk("rep_strobe_left", int'(l_stb), int'(xr.l));
        chk("rep_strobe_right", int'(r_stb), int'(xr.r));
      end
    end
  end

  // Scoreboard monitor, no-repeat instance.
  always @(negedge clk) begin
    if (q_one.size() > 0 && q_one[0].e < edge_cnt) begin
      chk("norep_missed_strobe_edge", -1, q_one[0].e);
      q_one.delete(0);
    end
    if (n_l_stb || n_r_stb) begin
      if (q_one.size() == 0) begin
        chk("norep_unexpected_strobe_edge", edge_cnt, -1);
      end else begin
        xo = q_one.pop_front();
        chk("norep_strobe_edge", edge_cnt, xo.e);
        chk("norep_strobe_left", int'(n_l_stb), int'(xo.l));
        chk("norep_strobe_right", int'(n_r_stb), int'(xo.r));
      end
    end
  end

  initial begin
    int e0, e1;

    // 1. Reset with inputs low, then 50 idle cycles.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_left_held", int'(l_held), 0);
    chk("reset_right_held", int'(r_held), 0);
    chk("reset_left_strobe", int'(l_stb), 0);
    chk("reset_right_strobe", int'(r_stb), 0);
    rst = 1'b0;
    wait_edge(edge_cnt + 50);
    chk("idle_left_held", int'(l_held), 0);
    chk("idle_right_held", int'(r_held), 0);

    // 2. Left held: strobes at +6, then +10, +15, +20 after the first.
    e0 = edge_cnt + 1;
    l_raw = 1'b1;
    push(e0 + LAT, 1'b1, 1'b0, 1'b1);
    push(e0 + LAT + RD, 1'b1, 1'b0, 1'b0);
    push(e0 + LAT + RD + RP, 1'b1, 1'b0, 1'b0);
    push(e0 + LAT + RD + 2 * RP, 1'b1, 1'b0, 1'b0);
    wait_edge(e0 + LAT - 1);
    chk("t2_left_held_before", int'(l_held), 0);
    wait_edge(e0 + LAT);
    chk("t2_left_held_after", int'(l_held), 1);
    // Raw low from edge e0+23: stable falls at e0+28, so the e0+31 repeat never comes.
    wait_edge(e0 + 22);
    l_raw = 1'b0;
    wait_edge(e0 + 28);
    chk("t2_left_held_late", int'(l_held), 1);
    wait_edge(e0 + 29);
    chk("t2_left_held_released", int'(l_held), 0);
    wait_edge(e0 + 40);

    // 3a. Right glitch, 3 cycles high: ignored.
    e0 = edge_cnt + 1;
    r_raw = 1'b1;
    wait_edge(e0 + 2);
    r_raw = 1'b0;
    wait_edge(e0 + 12);
    chk("t3_glitch_right_held", int'(r_held), 0);

    // 3b. Right pulse, 4 cycles high: one strobe, held falls 6 edges after raw falls.
    e0 = edge_cnt + 1;
    r_raw = 1'b1;
    push(e0 + LAT, 1'b0, 1'b1, 1'b1);
    wait_edge(e0 + 3);
    r_raw = 1'b0;
    wait_edge(e0 + LAT);
    chk("t3_pulse_right_held_on", int'(r_held), 1);
    wait_edge(e0 + 9);
    chk("t3_pulse_right_held_hold", int'(r_held), 1);
    wait_edge(e0 + 10);
    chk("t3_pulse_right_held_off", int'(r_held), 0);
    wait_edge(e0 + 20);

    // 4. Both buttons together: strobes and repeats aligned.
    e0 = edge_cnt + 1;
    l_raw = 1'b1;
    r_raw = 1'b1;
    push(e0 + LAT, 1'b1, 1'b1, 1'b1);
    push(e0 + LAT + RD, 1'b1, 1'b1, 1'b0);
    push(e0 + LAT + RD + RP, 1'b1, 1'b1, 1'b0);
    wait_edge(e0 + LAT);
    chk("t4_both_held", int'({l_held, r_held}), 3);
    // Raw low from e0+18: stable falls at e0+23, cancelling the e0+26 repeat.
    wait_edge(e0 + 17);
    l_raw = 1'b0;
    r_raw = 1'b0;
    wait_edge(e0 + 35);

    // 5. Debounced release 3 cycles into REPEAT (entered at e0+16, stable
    //    falls at e0+19): the e0+21 repeat is cancelled. Re-press needs full latency.
    e0 = edge_cnt + 1;
    l_raw = 1'b1;
    push(e0 + LAT, 1'b1, 1'b0, 1'b1);
    push(e0 + LAT + RD, 1'b1, 1'b0, 1'b0);
    wait_edge(e0 + 13);
    l_raw = 1'b0;
    wait_edge(e0 + 20);
    chk("t5_left_held_released", int'(l_held), 0);
    wait_edge(e0 + 21);
    e1 = e0 + 22;
    l_raw = 1'b1;
    push(e1 + LAT, 1'b1, 1'b0, 1'b1);
    wait_edge(e1 + LAT - 1);
    chk("t5_repress_held_before", int'(l_held), 0);
    wait_edge(e1 + 7);
    chk("t5_repress_held_after", int'(l_held), 1);
    l_raw = 1'b0;
    wait_edge(e1 + 25);

    // 6. One-cycle reset during REPEAT with the button held.
    e0 = edge_cnt + 1;
    l_raw = 1'b1;
    push(e0 + LAT, 1'b1, 1'b0, 1'b1);
    push(e0 + LAT + RD, 1'b1, 1'b0, 1'b0);
    wait_edge(e0 + 17);
    rst = 1'b1;
    wait_edge(e0 + 18);
    rst = 1'b0;
    chk("t6_reset_left_held", int'(l_held), 0);
    chk("t6_reset_left_strobe", int'(l_stb), 0);
    chk("t6_reset_norep_held", int'(n_l_held), 0);
    // Re-strobe 7 edges after the reset edge, then repeats resume from there.
    push(e0 + 18 + 7, 1'b1, 1'b0, 1'b1);
    push(e0 + 18 + 7 + RD, 1'b1, 1'b0, 1'b0);
    push(e0 + 18 + 7 + RD + RP, 1'b1, 1'b0, 1'b0);
    wait_edge(e0 + 36);
    l_raw = 1'b0;
    wait_edge(e0 + 55);

    chk("rep_queue_drained", q_rep.size(), 0);
    chk("norep_queue_drained", q_one.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
